// File: rtl/debounce8_if.sv
// Bus bundle for debounce8: raw input bus in, debounced bus and change strobes out.
// RISE/FALL exist only when DEBOUNCE8_EDGE_EN is defined.
interface debounce8_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] I;
    logic [WIDTH-1:0] O;
    logic             CHANGED;
`ifdef DEBOUNCE8_EDGE_EN
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;

    modport master (output I, input O, input CHANGED, input RISE, input FALL);
    modport slave  (input I, output O, output CHANGED, output RISE, output FALL);
`else
    modport master (output I, input O, input CHANGED);
    modport slave  (input I, output O, output CHANGED);
`endif
endinterface

// File: rtl/debounce8.sv
// Per-bit two-flop synchroniser plus stability-counter debouncer with a registered change strobe.
// Optional per-bit RISE/FALL strobes are built when DEBOUNCE8_EDGE_EN is defined.
module debounce8 #(
    parameter int WIDTH        = 8,
    parameter int CNT_BITS     = 16,
    parameter int STABLE_COUNT = 12000
) (
    input  logic      CLK,
    input  logic      RESET,
    debounce8_if.slave bus
);

    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(STABLE_COUNT - 1);

    logic [WIDTH-1:0]    s1;
    logic [WIDTH-1:0]    s2;
    logic [WIDTH-1:0]    o_q;
    logic [WIDTH-1:0]    o_nxt;
    logic [WIDTH-1:0]    upd;
    logic                changed_q;
    logic [CNT_BITS-1:0] cnt     [WIDTH];
    logic [CNT_BITS-1:0] cnt_nxt [WIDTH];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.I;
            s2 <= s1;
        end
    end

    // The compare at LAST clears the counter, so it never wraps.
    always_comb begin
        o_nxt = o_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (s2[i] == o_q[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == LAST) begin
                o_nxt[i]   = s2[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_BITS'(1);
            end
        end
        upd = o_nxt ^ o_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            o_q       <= '0;
            changed_q <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            o_q       <= o_nxt;
            changed_q <= |upd;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign bus.O       = o_q;
    assign bus.CHANGED = changed_q;

`ifdef DEBOUNCE8_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= upd & o_nxt;
            fall_q <= upd & ~o_nxt;
        end
    end

    assign bus.RISE = rise_q;
    assign bus.FALL = fall_q;
`endif

endmodule
